// File: rtl/bcd_run_ctrl_pkg.sv
// rtl/bcd_run_ctrl_pkg.sv - shared types and constants for the BCD run/stop sequencer
package bcd_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int BCD3_W = 12;
  typedef logic [BCD3_W-1:0] bcd3_t;

  localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

  function automatic logic bcd3_valid(input bcd3_t v);
    return (v[3:0] <= BCD_DIGIT_MAX) && (v[7:4] <= BCD_DIGIT_MAX) &&
           (v[11:8] <= BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_run_ctrl_tick_prescaler.sv
// rtl/bcd_run_ctrl_tick_prescaler.sv - modulo-TICK_DIV prescaler with hold, sync zero and terminal flag
module tick_prescaler #(
  parameter int TICK_DIV = 10,
  parameter int PW       = 10
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          zero,
  input  logic          inc,
  output logic [PW-1:0] count,
  output logic          tc
);

  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  assign tc = (count == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (zero) begin
      count <= '0;
    end else if (inc) begin
      count <= tc ? '0 : count + PW'(1);
    end
  end

endmodule

// File: rtl/bcd_run_ctrl.sv
// rtl/bcd_run_ctrl.sv - run/pause/done sequencer driving enable and clear of a 3-digit BCD counter
module bcd_run_ctrl
  import bcd_run_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int PW       = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        clr_req,
  input  logic [11:0] target,
  input  logic [3:0]  qout1,
  input  logic [3:0]  qout2,
  input  logic [3:0]  qout3,
  input  logic        cout,
  output logic        enable,
  output logic        clear,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [1:0]  state
);

  state_t         st;
  bcd3_t          count_val;
  logic           match;
  logic           take_start;
  logic           clear_nxt;
  logic           enable_nxt;
  logic           pres_zero;
  logic           pres_inc;
  logic [PW-1:0]  pres_count;
  logic           pres_tc;

  assign count_val = {qout3, qout2, qout1};

  // While clear is out the counter still shows the old value, so a restart
  // from DONE must not see a stale match against the target.
  assign match = bcd3_valid(target) && (count_val == target) && !clear;

  assign take_start = start && !stop && !clr_req;
  assign clear_nxt  = clr_req || (st == ST_DONE && take_start);
  assign enable_nxt = (st == ST_RUN) && !match && !stop && !clr_req && pres_tc;

  always_comb begin
    pres_zero = 1'b0;
    pres_inc  = 1'b0;
    case (st)
      ST_IDLE:  pres_zero = 1'b1;
      ST_RUN: begin
        if (clr_req)             pres_zero = 1'b1;
        else if (!stop && !match) pres_inc = 1'b1;
      end
      ST_PAUSE: pres_zero = clr_req;
      ST_DONE:  pres_zero = clr_req || take_start;
      default:  pres_zero = 1'b1;
    endcase
  end

  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .PW       (PW)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .zero  (pres_zero),
    .inc   (pres_inc),
    .count (pres_count),
    .tc    (pres_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st     <= ST_IDLE;
      enable <= 1'b0;
      clear  <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      enable <= enable_nxt;
      clear  <= clear_nxt;
      if (clear_nxt)          ovf <= 1'b0;
      else if (enable && cout) ovf <= 1'b1;
      case (st)
        ST_IDLE: begin
          if (take_start) st <= ST_RUN;
        end
        ST_RUN: begin
          if (clr_req)    st <= ST_IDLE;
          else if (stop)  st <= ST_PAUSE;
          else if (match) st <= ST_DONE;
        end
        ST_PAUSE, ST_DONE: begin
          if (clr_req)         st <= ST_IDLE;
          else if (take_start) st <= ST_RUN;
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  assign busy  = (st == ST_RUN);
  assign done  = (st == ST_DONE);
  assign state = st;

endmodule

// File: tb/tb_bcd_run_ctrl.sv
// tb/tb_bcd_run_ctrl.sv - directed self-checking bench for bcd_run_ctrl with a behavioural BCD counter
module tb_bcd_run_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop, clr_req;
  logic [11:0] target;
  logic [3:0]  qout1, qout2, qout3;
  logic        cout;
  logic        enable, clear, busy, done, ovf;
  logic [1:0]  state;

  int total = 0;
  int bad   = 0;
  int cnt;
  int k;
  int n_en;

  always #5 clk = ~clk;

  bcd_run_ctrl #(.TICK_DIV(10), .PW(10)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .clr_req (clr_req),
    .target  (target),
    .qout1   (qout1),
    .qout2   (qout2),
    .qout3   (qout3),
    .cout    (cout),
    .enable  (enable),
    .clear   (clear),
    .busy    (busy),
    .done    (done),
    .ovf     (ovf),
    .state   (state)
  );

  // 000..999 counter that the sequencer controls
  always @(posedge clk or posedge reset) begin
    if (reset)       cnt <= 0;
    else if (clear)  cnt <= 0;
    else if (enable) cnt <= (cnt == 999) ? 0 : cnt + 1;
  end
  assign qout1 = 4'(cnt % 10);
  assign qout2 = 4'((cnt / 10) % 10);
  assign qout3 = 4'(cnt / 100);
  assign cout  = enable && (cnt == 999);

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mask bits: 2=clr_req 1=stop 0=start; returns at the negedge after sampling
  task automatic pulse(input logic [2:0] m);
    clr_req = m[2];
    stop    = m[1];
    start   = m[0];
    @(negedge clk);
    clr_req = 1'b0;
    stop    = 1'b0;
    start   = 1'b0;
  endtask

  task automatic wait_en(input int maxc, output int kk);
    kk = 0;
    do begin
      @(negedge clk);
      kk++;
    end while (!enable && kk < maxc);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; clr_req = 1'b0; target = 12'h005;

    // 1: reset
    repeat (2) @(negedge clk);
    chk("rst_enable", enable, 0);
    chk("rst_clear", clear, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_state", state, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_state", state, 0);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_done", done, 0);

    // 2: run to 005
    pulse(3'b001);
    chk("run_state", state, 1);
    wait_en(30, k);
    chk("first_enable_lat", k, 10);
    for (int i = 0; i < 4; i++) begin
      wait_en(30, k);
      chk("enable_period", k, 10);
    end
    @(negedge clk);
    chk("cnt5_still_run", state, 1);
    @(negedge clk);
    chk("done_state", state, 3);
    chk("done_flag", done, 1);
    chk("done_busy", busy, 0);
    n_en = 0;
    repeat (100) begin
      @(negedge clk);
      if (enable) n_en++;
    end
    chk("done_no_enable", n_en, 0);

    // 3: pause and resume
    pulse(3'b100);
    chk("clr_from_done_state", state, 0);
    chk("clr_from_done_pulse", clear, 1);
    pulse(3'b001);
    for (int i = 0; i < 3; i++) begin
      wait_en(30, k);
      chk("pre_pause_period", k, 10);
    end
    repeat (4) @(negedge clk);
    pulse(3'b010);
    chk("pause_state", state, 2);
    chk("pause_count", qout1, 3);
    n_en = 0;
    repeat (20) begin
      @(negedge clk);
      if (enable) n_en++;
    end
    chk("pause_no_enable", n_en, 0);
    chk("pause_held", state, 2);
    pulse(3'b001);
    chk("resume_state", state, 1);
    wait_en(30, k);
    chk("resume_remaining", k, 6);
    wait_en(30, k);
    chk("resume_period", k, 10);
    repeat (2) @(negedge clk);
    chk("pause_done_state", state, 3);
    chk("pause_done_count", qout1, 5);

    // 4: auto-restart from DONE
    pulse(3'b001);
    chk("restart_clear", clear, 1);
    chk("restart_enable", enable, 0);
    chk("restart_state", state, 1);
    @(negedge clk);
    chk("restart_clear_gone", clear, 0);
    chk("restart_count0", cnt, 0);
    n_en = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (enable) n_en++;
      if (state == 2'd3) break;
    end
    chk("restart_enables", n_en, 5);
    chk("restart_done", state, 3);
    chk("restart_count5", qout1, 5);

    // 5: invalid target, wrap past 999
    pulse(3'b100);
    target = 12'h0A0;
    pulse(3'b001);
    n_en = 0;
    for (int i = 0; i < 11000; i++) begin
      @(negedge clk);
      if (ovf) break;
      if (enable) n_en++;
    end
    chk("wrap_enables", n_en, 1000);
    chk("wrap_ovf", ovf, 1);
    chk("wrap_count", {qout3, qout2, qout1}, 0);
    chk("wrap_still_run", state, 1);
    repeat (15) @(negedge clk);
    chk("ovf_sticky", ovf, 1);
    pulse(3'b100);
    chk("ovf_clr_pulse", clear, 1);
    chk("ovf_cleared", ovf, 0);
    chk("ovf_clr_state", state, 0);

    // 6: all commands together exactly when an enable is due
    pulse(3'b001);
    repeat (9) @(negedge clk);
    pulse(3'b111);
    chk("all_cmd_clear", clear, 1);
    chk("all_cmd_enable", enable, 0);
    chk("all_cmd_state", state, 0);
    @(negedge clk);
    chk("all_cmd_clear_once", clear, 0);
    chk("all_cmd_no_enable", enable, 0);

    // async reset mid-RUN while enable is high
    pulse(3'b001);
    wait_en(30, k);
    chk("pre_reset_enable", enable, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_enable", enable, 0);
    chk("async_state", state, 0);
    chk("async_busy", busy, 0);
    #1 reset = 1'b0;
    @(negedge clk);

    // start while already matched: one RUN cycle then DONE
    target = 12'h000;
    pulse(3'b001);
    chk("matched_run", state, 1);
    chk("matched_run_en", enable, 0);
    @(negedge clk);
    chk("matched_done", state, 3);
    chk("matched_done_en", enable, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_run_ctrl.md
Name: bcd_run_ctrl

Overview:
Run/stop sequencer for the 3-digit cascaded BCD counter (ones/tens/hundreds, `enable`/`clear` inputs, `cout` carry).
- Accepts single-cycle start/stop/clear commands.
- Generates a prescaled `enable` tick and a one-cycle `clear` pulse for the counter.
- Watches the counter outputs and halts counting when they equal a programmed BCD target.
- Sits between the user-command/debounce logic and the counter top.

Parameters:
- TICK_DIV, 10: clocks per counter increment. Legal range 2..1023; 1 is illegal.
- PW, 10: prescaler width. Must satisfy 2^PW >= TICK_DIV.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle command pulse: run or resume.
- stop  in  1  one-cycle command pulse: pause.
- clr_req  in  1  one-cycle command pulse: clear counter and go idle.
- target  in  12  BCD target {hundreds, tens, ones}, 4 bits per digit.
- qout1  in  4  counter ones digit.
- qout2  in  4  counter tens digit.
- qout3  in  4  counter hundreds digit.
- cout  in  1  counter carry out (high at 999 while enabled).
- enable  out  1  registered counter enable pulse.
- clear  out  1  registered counter clear pulse.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- ovf  out  1  sticky wrap flag.
- state  out  2  current FSM state.

Behaviour:
- Reset (asynchronous, active-high) sets state=IDLE, prescaler=0, and enable, clear, ovf all 0. busy and done are then 0.
- State encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3. busy = (state==RUN); done = (state==DONE).
- match = ({qout3,qout2,qout1} == target), exact 12-bit compare. A target with any digit >9 never matches.
- Command priority within one cycle: clr_req > stop > start. Lower-priority commands in the same cycle are ignored.
- Transitions:
  - IDLE: start -> RUN with prescaler=0. clr_req -> clear pulse, stay IDLE.
  - RUN: clr_req -> clear pulse, IDLE. stop -> PAUSE with prescaler held. match -> DONE. Otherwise stay RUN.
  - PAUSE: start -> RUN, prescaler resumes from its held value. clr_req -> clear pulse, IDLE. stop is ignored.
  - DONE: start -> clear pulse, RUN with prescaler=0 (auto-restart from 000). clr_req -> clear pulse, IDLE. stop is ignored.
- Prescaler:
  - Increments every clock in RUN when no command is taken and match=0.
  - Wraps TICK_DIV-1 -> 0.
  - Holds in PAUSE and DONE; is 0 in IDLE.
- enable:
  - Registered next-cycle value = (state==RUN) && !match && !stop && !clr_req && (prescaler==TICK_DIV-1).
  - Exactly one clock high per TICK_DIV clocks of uninterrupted RUN.
  - First enable occurs TICK_DIV clocks after the start pulse is sampled.
- clear:
  - Registered, high for exactly one clock on the cycle after the triggering command is sampled.
  - enable is never high in the same cycle as clear.
- Match timing:
  - The counter updates on the edge that ends an enable cycle; the new qout is compared on the next cycle.
  - TICK_DIV>=2 guarantees no enable is issued before the compare, so the counter never overshoots the target.
- Start when already matched: start in IDLE or PAUSE while match=1 -> RUN for one cycle, then DONE, with no enable issued.
- ovf:
  - Set when enable && cout are both high (counter wraps 999->000).
  - Cleared only by reset or a clear pulse.
  - If set and clear occur in the same cycle, clear wins.
- Reset mid-operation: enable and clear drop immediately (asynchronously); any pending pulse is lost.

Decomposition:
- Package bcd_run_ctrl_pkg:
  - state constants ST_IDLE, ST_RUN, ST_PAUSE, ST_DONE;
  - 12-bit bcd3_t type or width constant;
  - BCD digit max constant 4'd9.
- One natural sub-module, tick_prescaler (count, hold, sync-zero, terminal-count flag), parameterised by TICK_DIV/PW.
- FSM, compare and ovf logic stay in the top.

Test Plan:
1. Reset asserted for 20 ns -> enable=0, clear=0, ovf=0, state=0 held. Release reset -> outputs still 0, state=IDLE.
2. TICK_DIV=10, target=12'h005, start pulse -> first enable 10 clocks later, then one every 10 clocks. Counter reaches 005 -> state=DONE, done=1, and no further enable for 100 clocks.
3. Running with count at 003, stop pulse -> state=PAUSE, enable stays 0 and prescaler holds. start pulse -> RUN; the next enable arrives after exactly the remaining prescaler count, with no lost or extra tick.
4. In DONE at 005, start pulse -> one-cycle clear, counter reads 000, RUN resumes, and it reaches DONE again after 5 enables.
5. target=12'h0A0 (invalid digit), run past 999 -> an enable with cout=1 sets ovf=1 and the counter wraps to 000. A later clr_req -> clear pulse, ovf=0, state=IDLE.
6. clr_req, stop and start all in one cycle while in RUN -> clear pulse, state=IDLE, no enable. Reset asserted mid-RUN -> enable=0 and state=IDLE immediately, before the next clock edge.
